// File: rtl/mpi_pkt_decoder.sv
// Snoops a 64-bit packet stream and classifies UDP/IPv4 packets carrying an MPI header.
// Defining MPI_DECODE_STATS_EN adds per-outcome packet counters; otherwise they read as 0.
module mpi_pkt_decoder #(
  parameter int          DATA_WIDTH      = 64,
  parameter int          CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter logic [15:0] MPI_UDP_PORT    = 16'hB111,
  parameter int          PORT_MATCH_MODE = 1,
  parameter int          CHECK_IP_HDR    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  decode_done,
  output logic                  mpi_pkt,
  output logic                  not_mpi_pkt,
  output logic                  runt_pkt,
  output logic [15:0]           message,
  output logic [15:0]           comm_id,
  output logic [7:0]            topo_type,
  output logic [7:0]            node_type,
  output logic [47:0]           src_mac,
  output logic [47:0]           dst_mac,
  output logic [31:0]           src_ip,
  output logic [31:0]           dst_ip,
  output logic [15:0]           ip_cksum,
  output logic [15:0]           udp_src,
  output logic [15:0]           udp_dst,
  output logic [31:0]           mpi_cnt,
  output logic [31:0]           other_cnt,
  output logic [31:0]           runt_cnt
);

  typedef enum logic [2:0] {
    READ_WORD_1 = 3'd0,
    READ_WORD_2 = 3'd1,
    READ_WORD_3 = 3'd2,
    READ_WORD_4 = 3'd3,
    READ_WORD_5 = 3'd4,
    READ_WORD_6 = 3'd5,
    WAIT_EOP    = 3'd6
  } state_t;

  state_t      state_r;
  logic [15:0] ethertype_r;
  logic [7:0]  ver_ihl_r;
  logic [7:0]  protocol_r;

  logic eop_s;
  logic port_ok_s;
  logic hdr_ok_s;
  logic match_s;
  logic mid_hdr_s;
  logic runt_evt_s;
  logic other_evt_s;
  logic mpi_evt_s;

  // Match evaluation and per-word outcome events; UDP ports come straight off the word-5 bus.
  always_comb begin
    eop_s = (in_ctrl != {CTRL_WIDTH{1'b0}});
    if (PORT_MATCH_MODE == 0) begin
      port_ok_s = (in_data[31:16] == MPI_UDP_PORT);
    end else begin
      port_ok_s = (in_data[31:16] == MPI_UDP_PORT) || (in_data[47:32] == MPI_UDP_PORT);
    end
    if (CHECK_IP_HDR != 0) begin
      hdr_ok_s = (ethertype_r == 16'h0800) && (ver_ihl_r == 8'h45) && (protocol_r == 8'd17);
    end else begin
      hdr_ok_s = 1'b1;
    end
    match_s = port_ok_s && hdr_ok_s;
    case (state_r)
      READ_WORD_2, READ_WORD_3, READ_WORD_4, READ_WORD_5: mid_hdr_s = 1'b1;
      default:                                            mid_hdr_s = 1'b0;
    endcase
    runt_evt_s  = in_wr && eop_s && mid_hdr_s;
    other_evt_s = in_wr && !eop_s && (state_r == READ_WORD_5) && !match_s;
    mpi_evt_s   = in_wr && (state_r == READ_WORD_6);
  end

  // Header walk: captures fields word by word and registers the classification outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= READ_WORD_1;
      ethertype_r <= 16'd0;
      ver_ihl_r   <= 8'd0;
      protocol_r  <= 8'd0;
      decode_done <= 1'b0;
      mpi_pkt     <= 1'b0;
      not_mpi_pkt <= 1'b0;
      runt_pkt    <= 1'b0;
      message     <= 16'd0;
      comm_id     <= 16'd0;
      topo_type   <= 8'd0;
      node_type   <= 8'd0;
      src_mac     <= 48'd0;
      dst_mac     <= 48'd0;
      src_ip      <= 32'd0;
      dst_ip      <= 32'd0;
      ip_cksum    <= 16'd0;
      udp_src     <= 16'd0;
      udp_dst     <= 16'd0;
    end else begin
      decode_done <= 1'b0;
      if (in_wr) begin
        if (runt_evt_s) begin
          // Packet ended before the UDP ports were seen.
          not_mpi_pkt <= 1'b1;
          runt_pkt    <= 1'b1;
          message     <= 16'd0;
          comm_id     <= 16'd0;
          topo_type   <= 8'd0;
          node_type   <= 8'd0;
          decode_done <= 1'b1;
          state_r     <= READ_WORD_1;
        end else begin
          case (state_r)
            READ_WORD_1: begin
              if (!eop_s) begin
                mpi_pkt         <= 1'b0;
                not_mpi_pkt     <= 1'b0;
                runt_pkt        <= 1'b0;
                dst_mac         <= in_data[63:16];
                src_mac[47:32]  <= in_data[15:0];
                state_r         <= READ_WORD_2;
              end
            end
            READ_WORD_2: begin
              src_mac[31:0] <= in_data[63:32];
              ethertype_r   <= in_data[31:16];
              ver_ihl_r     <= in_data[15:8];
              state_r       <= READ_WORD_3;
            end
            READ_WORD_3: begin
              protocol_r <= in_data[7:0];
              state_r    <= READ_WORD_4;
            end
            READ_WORD_4: begin
              ip_cksum      <= in_data[63:48];
              src_ip        <= in_data[47:16];
              dst_ip[31:16] <= in_data[15:0];
              state_r       <= READ_WORD_5;
            end
            READ_WORD_5: begin
              dst_ip[15:0] <= in_data[63:48];
              udp_src      <= in_data[47:32];
              udp_dst      <= in_data[31:16];
              state_r      <= match_s ? READ_WORD_6 : WAIT_EOP;
            end
            READ_WORD_6: begin
              message   <= in_data[47:32];
              comm_id   <= in_data[31:16];
              topo_type <= in_data[15:8];
              node_type <= in_data[7:0];
              state_r   <= eop_s ? READ_WORD_1 : WAIT_EOP;
            end
            WAIT_EOP: begin
              if (eop_s) begin
                state_r <= READ_WORD_1;
              end
            end
            default: state_r <= READ_WORD_1;
          endcase
          if (other_evt_s) begin
            not_mpi_pkt <= 1'b1;
            message     <= 16'd0;
            comm_id     <= 16'd0;
            topo_type   <= 8'd0;
            node_type   <= 8'd0;
            decode_done <= 1'b1;
          end
          if (mpi_evt_s) begin
            mpi_pkt     <= 1'b1;
            decode_done <= 1'b1;
          end
        end
      end
    end
  end

`ifdef MPI_DECODE_STATS_EN
  // Outcome counters update on the same edge that raises decode_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      mpi_cnt   <= 32'd0;
      other_cnt <= 32'd0;
      runt_cnt  <= 32'd0;
    end else begin
      if (mpi_evt_s) begin
        mpi_cnt <= mpi_cnt + 32'd1;
      end
      if (other_evt_s) begin
        other_cnt <= other_cnt + 32'd1;
      end
      if (runt_evt_s) begin
        runt_cnt <= runt_cnt + 32'd1;
      end
    end
  end
`else
  assign mpi_cnt   = 32'd0;
  assign other_cnt = 32'd0;
  assign runt_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_mpi_pkt_decoder.sv
// Randomized bench for mpi_pkt_decoder: two instances (port match mode 1 and 0) checked
// against a packet-level reference model built from the field layout and match rules.
module tb_mpi_pkt_decoder;

  localparam logic [15:0] MPI_PORT = 16'hB111;

  logic        clk;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;

  logic        d1_decode_done, d1_mpi_pkt, d1_not_mpi_pkt, d1_runt_pkt;
  logic [15:0] d1_message, d1_comm_id, d1_ip_cksum, d1_udp_src, d1_udp_dst;
  logic [7:0]  d1_topo_type, d1_node_type;
  logic [47:0] d1_src_mac, d1_dst_mac;
  logic [31:0] d1_src_ip, d1_dst_ip, d1_mpi_cnt, d1_other_cnt, d1_runt_cnt;

  logic        d0_decode_done, d0_mpi_pkt, d0_not_mpi_pkt, d0_runt_pkt;
  logic [15:0] d0_message, d0_comm_id, d0_ip_cksum, d0_udp_src, d0_udp_dst;
  logic [7:0]  d0_topo_type, d0_node_type;
  logic [47:0] d0_src_mac, d0_dst_mac;
  logic [31:0] d0_src_ip, d0_dst_ip, d0_mpi_cnt, d0_other_cnt, d0_runt_cnt;

  mpi_pkt_decoder #(.PORT_MATCH_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .decode_done(d1_decode_done), .mpi_pkt(d1_mpi_pkt), .not_mpi_pkt(d1_not_mpi_pkt),
    .runt_pkt(d1_runt_pkt), .message(d1_message), .comm_id(d1_comm_id),
    .topo_type(d1_topo_type), .node_type(d1_node_type), .src_mac(d1_src_mac),
    .dst_mac(d1_dst_mac), .src_ip(d1_src_ip), .dst_ip(d1_dst_ip), .ip_cksum(d1_ip_cksum),
    .udp_src(d1_udp_src), .udp_dst(d1_udp_dst), .mpi_cnt(d1_mpi_cnt),
    .other_cnt(d1_other_cnt), .runt_cnt(d1_runt_cnt)
  );

  mpi_pkt_decoder #(.PORT_MATCH_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .decode_done(d0_decode_done), .mpi_pkt(d0_mpi_pkt), .not_mpi_pkt(d0_not_mpi_pkt),
    .runt_pkt(d0_runt_pkt), .message(d0_message), .comm_id(d0_comm_id),
    .topo_type(d0_topo_type), .node_type(d0_node_type), .src_mac(d0_src_mac),
    .dst_mac(d0_dst_mac), .src_ip(d0_src_ip), .dst_ip(d0_dst_ip), .ip_cksum(d0_ip_cksum),
    .udp_src(d0_udp_src), .udp_dst(d0_udp_dst), .mpi_cnt(d0_mpi_cnt),
    .other_cnt(d0_other_cnt), .runt_cnt(d0_runt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        mpi;
    logic        notmpi;
    logic        runt;
    logic [15:0] message;
    logic [15:0] comm_id;
    logic [7:0]  topo;
    logic [7:0]  node;
    logic [47:0] src_mac;
    logic [47:0] dst_mac;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] ip_cksum;
    logic [15:0] udp_src;
    logic [15:0] udp_dst;
  } res_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t cur1, cur0, pe1, pe0, res1, res0;
  int   dec1, dec0;
  logic pend1, pend0;
  logic [2:0] fl1, fl0;
  int   cnt_mpi, cnt_other, cnt_runt, pc_mpi, pc_other, pc_runt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_cnt(input int c);
`ifdef MPI_DECODE_STATS_EN
    return c;
`else
    return 0;
`endif
  endfunction

  task automatic check_fields1();
    check_eq("mpi_pkt", d1_mpi_pkt, res1.mpi);
    check_eq("not_mpi_pkt", d1_not_mpi_pkt, res1.notmpi);
    check_eq("runt_pkt", d1_runt_pkt, res1.runt);
    check_eq("message", d1_message, res1.message);
    check_eq("comm_id", d1_comm_id, res1.comm_id);
    check_eq("topo_type", d1_topo_type, res1.topo);
    check_eq("node_type", d1_node_type, res1.node);
    check_eq("src_mac", d1_src_mac, res1.src_mac);
    check_eq("dst_mac", d1_dst_mac, res1.dst_mac);
    check_eq("src_ip", d1_src_ip, res1.src_ip);
    check_eq("dst_ip", d1_dst_ip, res1.dst_ip);
    check_eq("ip_cksum", d1_ip_cksum, res1.ip_cksum);
    check_eq("udp_src", d1_udp_src, res1.udp_src);
    check_eq("udp_dst", d1_udp_dst, res1.udp_dst);
    check_eq("mpi_cnt", d1_mpi_cnt, exp_cnt(pc_mpi));
    check_eq("other_cnt", d1_other_cnt, exp_cnt(pc_other));
    check_eq("runt_cnt", d1_runt_cnt, exp_cnt(pc_runt));
  endtask

  // One clock: check what the previous inputs produced, then drive the next inputs.
  task automatic step(input logic [63:0] d, input logic [7:0] c, input logic w, input int widx);
    @(posedge clk);
    #1;
    check_eq("done1", d1_decode_done, pend1);
    check_eq("flags1", {d1_mpi_pkt, d1_not_mpi_pkt, d1_runt_pkt}, fl1);
    check_eq("done0", d0_decode_done, pend0);
    check_eq("flags0", {d0_mpi_pkt, d0_not_mpi_pkt, d0_runt_pkt}, fl0);
    if (pend1) check_fields1();
    if (pend0) check_eq("message0", d0_message, res0.message);
    in_data = d;
    in_ctrl = c;
    in_wr   = w;
    pend1 = 1'b0;
    pend0 = 1'b0;
    if (w && widx == 1) begin
      fl1 = 3'b000;
      fl0 = 3'b000;
    end
    if (w && widx > 0 && widx == dec1) begin
      pend1 = 1'b1;
      res1 = pe1;
      fl1 = {pe1.mpi, pe1.notmpi, pe1.runt};
      pc_mpi = cnt_mpi;
      pc_other = cnt_other;
      pc_runt = cnt_runt;
    end
    if (w && widx > 0 && widx == dec0) begin
      pend0 = 1'b1;
      res0 = pe0;
      fl0 = {pe0.mpi, pe0.notmpi, pe0.runt};
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_wr = 1'b0;
    in_ctrl = 8'd0;
    in_data = 64'd0;
    pend1 = 1'b0; pend0 = 1'b0; fl1 = 3'b000; fl0 = 3'b000;
    cur1 = '0; cur0 = '0;
    cnt_mpi = 0; cnt_other = 0; cnt_runt = 0;
    step(64'd0, 8'd0, 1'b0, 0);
    step(64'd0, 8'd0, 1'b0, 0);
    reset = 1'b0;
    check_eq("rst_done", d1_decode_done, 1'b0);
    res1 = '0;
    pc_mpi = 0; pc_other = 0; pc_runt = 0;
    check_fields1();
  endtask

  // Packet-level reference: which fields the packet delivers, and on which word it is decided.
  task automatic model(input int m, input res_t prev, input int n,
                       input logic [47:0] dm, input logic [47:0] sm,
                       input logic [31:0] sip, input logic [31:0] dip, input logic [15:0] ck,
                       input logic [15:0] et, input logic [7:0] vi, input logic [7:0] pr,
                       input logic [15:0] us, input logic [15:0] ud, input logic [63:0] w6,
                       output res_t r, output int dec);
    bit port_ok, hdr_ok;
    r = prev;
    r.mpi = 1'b0; r.notmpi = 1'b0; r.runt = 1'b0;
    if (n > 1) begin
      r.dst_mac = dm;
      r.src_mac[47:32] = sm[47:32];
    end
    if (n > 2) r.src_mac[31:0] = sm[31:0];
    if (n > 4) begin
      r.ip_cksum = ck;
      r.src_ip = sip;
      r.dst_ip[31:16] = dip[31:16];
    end
    if (n <= 5) begin
      r.notmpi = 1'b1; r.runt = 1'b1;
      r.message = 16'd0; r.comm_id = 16'd0; r.topo = 8'd0; r.node = 8'd0;
      dec = n;
    end else begin
      r.dst_ip[15:0] = dip[15:0];
      r.udp_src = us;
      r.udp_dst = ud;
      port_ok = (m == 0) ? (ud == MPI_PORT) : (ud == MPI_PORT || us == MPI_PORT);
      hdr_ok = (et == 16'h0800) && (vi == 8'h45) && (pr == 8'd17);
      if (port_ok && hdr_ok) begin
        r.mpi = 1'b1;
        r.message = w6[47:32]; r.comm_id = w6[31:16]; r.topo = w6[15:8]; r.node = w6[7:0];
        dec = 6;
      end else begin
        r.notmpi = 1'b1;
        r.message = 16'd0; r.comm_id = 16'd0; r.topo = 8'd0; r.node = 8'd0;
        dec = 5;
      end
    end
  endtask

  task automatic send_pkt(input int n, input logic [15:0] et, input logic [7:0] vi,
                          input logic [7:0] pr, input logic [15:0] us, input logic [15:0] ud,
                          input logic [63:0] w6, input int gap_mode, input int stop_at);
    logic [63:0] r64;
    logic [47:0] dm, sm;
    logic [31:0] sip, dip;
    logic [15:0] ck;
    logic [63:0] w [1:10];
    logic [7:0]  c;
    int last;
    r64 = {$urandom, $urandom}; dm = r64[47:0];
    r64 = {$urandom, $urandom}; sm = r64[47:0];
    sip = $urandom; dip = $urandom; ck = 16'($urandom);
    r64 = {$urandom, $urandom};
    w[1] = {dm, sm[47:32]};
    w[2] = {sm[31:0], et, vi, r64[7:0]};
    w[3] = {r64[63:8], pr};
    w[4] = {ck, sip, dip[31:16]};
    w[5] = {dip[15:0], us, ud, r64[15:0]};
    w[6] = w6;
    for (int k = 7; k <= 10; k++) w[k] = {$urandom, $urandom};
    model(1, cur1, n, dm, sm, sip, dip, ck, et, vi, pr, us, ud, w6, pe1, dec1);
    model(0, cur0, n, dm, sm, sip, dip, ck, et, vi, pr, us, ud, w6, pe0, dec0);
    if (stop_at == 0) begin
      if (pe1.runt) cnt_runt++;
      else if (pe1.mpi) cnt_mpi++;
      else cnt_other++;
    end
    if ($urandom_range(0, 2) == 0) step({$urandom, $urandom}, 8'hFF, 1'b1, 0);
    last = (stop_at > 0) ? stop_at : n;
    for (int k = 1; k <= last; k++) begin
      if (gap_mode == 1) begin
        repeat ($urandom_range(0, 2)) step({$urandom, $urandom}, 8'($urandom), 1'b0, 0);
      end else if (gap_mode == 2 && k == 5) begin
        repeat (3) step({$urandom, $urandom}, 8'($urandom), 1'b0, 0);
      end
      c = (k == n) ? 8'($urandom_range(1, 255)) : 8'h00;
      step(w[k], c, 1'b1, k);
    end
    if (stop_at == 0) begin
      cur1 = pe1;
      cur0 = pe0;
    end
  endtask

  function automatic logic [15:0] pick_port();
    case ($urandom_range(0, 2))
      0:       return MPI_PORT;
      1:       return 16'd80;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] et;
    logic [7:0]  vi, pr;
    do_reset();
    // Directed: good MPI packet, plain UDP, source-port-only match, runt, gapped back-to-back.
    send_pkt(6, 16'h0800, 8'h45, 8'd17, 16'h1234, MPI_PORT, 64'h0000_0003_0007_0102, 0, 0);
    send_pkt(8, 16'h0800, 8'h45, 8'd17, 16'd80, 16'd80, {$urandom, $urandom}, 0, 0);
    send_pkt(6, 16'h0800, 8'h45, 8'd17, MPI_PORT, 16'd1234, 64'h0000_0011_0022_0304, 0, 0);
    send_pkt(3, 16'h0800, 8'h45, 8'd17, 16'd80, MPI_PORT, {$urandom, $urandom}, 0, 0);
    send_pkt(7, 16'h0800, 8'h45, 8'd17, 16'd5, MPI_PORT, 64'h0000_00AA_00BB_0C0D, 2, 0);
    send_pkt(6, 16'h0800, 8'h45, 8'd17, 16'd5, MPI_PORT, 64'h0000_00AA_00BB_0C0D, 0, 0);
    send_pkt(6, 16'h86DD, 8'h45, 8'd17, 16'd5, MPI_PORT, {$urandom, $urandom}, 0, 0);
    // Abort mid-packet with reset, then a clean MPI packet.
    send_pkt(6, 16'h0800, 8'h45, 8'd17, 16'd5, MPI_PORT, {$urandom, $urandom}, 0, 3);
    do_reset();
    send_pkt(6, 16'h0800, 8'h45, 8'd17, 16'd9, MPI_PORT, 64'h0000_0003_0007_0102, 0, 0);
    for (int i = 0; i < 80; i++) begin
      et = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0800;
      vi = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h45;
      pr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'd17;
      send_pkt($urandom_range(2, 8), et, vi, pr, pick_port(), pick_port(),
               {$urandom, $urandom}, $urandom_range(0, 1), 0);
    end
    step(64'd0, 8'd0, 1'b0, 0);
    step(64'd0, 8'd0, 1'b0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
